// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Snapshots digit data once per frame, then lights one digit at a time with an optional blank gap.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIG   = 8,
    parameter int unsigned SHOW_CYC  = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [4*NUM_DIG-1:0]   din,
    input  logic [NUM_DIG-1:0]     dp_in,
    input  logic [NUM_DIG-1:0]     blank_in,
    output logic [3:0]             code,
    output logic [NUM_DIG-1:0]     sel_n,
    output logic                   dp_n,
    output logic                   frame_start
);
    localparam int unsigned MAX_CYC  = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
    localparam int unsigned CW       = $clog2(MAX_CYC + 1);
    localparam int unsigned IW       = $clog2(NUM_DIG);
    localparam logic [CW-1:0] SHOW_LD  = CW'(SHOW_CYC - 1);
    localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIG - 1);
    localparam logic [3:0]    CODE_OFF = 4'hB;

    typedef enum logic [1:0] {IDLE, LOAD, SHOW, BLANK} state_t;

    state_t               state, state_nx;
    logic [IW-1:0]        idx, idx_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic [4*NUM_DIG-1:0] snap_din, snap_din_nx;
    logic [NUM_DIG-1:0]   snap_dp, snap_dp_nx;
    logic [NUM_DIG-1:0]   snap_blank, snap_blank_nx;
    logic [3:0]           code_nx;
    logic [NUM_DIG-1:0]   sel_n_nx;
    logic                 dp_n_nx;

    always_comb begin
        state_nx      = state;
        idx_nx        = idx;
        cnt_nx        = cnt;
        snap_din_nx   = snap_din;
        snap_dp_nx    = snap_dp;
        snap_blank_nx = snap_blank;

        if (state == LOAD) begin
            snap_din_nx   = din;
            snap_dp_nx    = dp_in;
            snap_blank_nx = blank_in;
        end

        case (state)
            IDLE: begin
                if (en) state_nx = LOAD;
            end
            LOAD: begin
                idx_nx = '0;
                if (!en) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = SHOW;
                    cnt_nx   = SHOW_LD;
                end
            end
            SHOW, BLANK: begin
                if (!en) begin
                    state_nx = IDLE;
                end else if (cnt != '0) begin
                    cnt_nx = cnt - CW'(1);
                end else if (state == SHOW && BLANK_CYC > 0) begin
                    state_nx = BLANK;
                    cnt_nx   = BLANK_LD;
                end else if (idx != LAST_IDX) begin
                    idx_nx   = idx + IW'(1);
                    state_nx = SHOW;
                    cnt_nx   = SHOW_LD;
                end else begin
                    state_nx = LOAD;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Outputs come from the next-state view so the registered pins line up with the state.
        sel_n_nx = '1;
        code_nx  = CODE_OFF;
        dp_n_nx  = 1'b1;
        if (state_nx == SHOW && !snap_blank_nx[idx_nx]) begin
            for (int unsigned i = 0; i < NUM_DIG; i++) begin
                if (IW'(i) == idx_nx) begin
                    sel_n_nx[i] = 1'b0;
                    code_nx     = snap_din_nx[4*i +: 4];
                    dp_n_nx     = ~snap_dp_nx[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            snap_din    <= '0;
            snap_dp     <= '0;
            snap_blank  <= '0;
            sel_n       <= '1;
            code        <= CODE_OFF;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            cnt         <= cnt_nx;
            snap_din    <= snap_din_nx;
            snap_dp     <= snap_dp_nx;
            snap_blank  <= snap_blank_nx;
            sel_n       <= sel_n_nx;
            code        <= code_nx;
            dp_n        <= dp_n_nx;
            frame_start <= (state_nx == LOAD);
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (with and without blank gap) checked every cycle
// against a frame-position model, plus literal frame sequences and reset/enable scenarios.
module tb_seg_scan_ctrl;
    localparam int N = 4;
    localparam int S = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [15:0] din = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;

    logic [3:0] code_a, sel_a, code_b, sel_b;
    logic       dp_a, fs_a, dp_b, fs_b;

    seg_scan_ctrl #(.NUM_DIG(4), .SHOW_CYC(3), .BLANK_CYC(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .din(din), .dp_in(dp_in), .blank_in(blank_in),
        .code(code_a), .sel_n(sel_a), .dp_n(dp_a), .frame_start(fs_a));

    seg_scan_ctrl #(.NUM_DIG(4), .SHOW_CYC(3), .BLANK_CYC(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .din(din), .dp_in(dp_in), .blank_in(blank_in),
        .code(code_b), .sel_n(sel_b), .dp_n(dp_b), .frame_start(fs_b));

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    bit run_cmp = 1'b0;

    typedef struct packed {
        logic       fs;
        logic [3:0] sel_n;
        logic [3:0] code;
        logic       dp_n;
    } out_t;

    typedef struct {
        bit          active;
        int          t;
        logic [15:0] d;
        logic [3:0]  dp;
        logic [3:0]  bl;
    } mdl_t;

    mdl_t m[2];
    int   blank_cyc[2] = '{1, 0};
    logic [3:0] lit_sel[4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Position t within a frame: t=0 is the snapshot cycle, then NUM_DIG slots of S+B cycles.
    function automatic out_t expect_out(input mdl_t s, input int b);
        out_t o;
        int slot, off;
        o.fs = 1'b0; o.sel_n = 4'hF; o.code = 4'hB; o.dp_n = 1'b1;
        if (s.active && s.t == 0) begin
            o.fs = 1'b1;
        end else if (s.active) begin
            slot = (s.t - 1) / (S + b);
            off  = (s.t - 1) % (S + b);
            if (off < S && !s.bl[slot]) begin
                o.sel_n = ~(4'b0001 << slot);
                o.code  = s.d[slot*4 +: 4];
                o.dp_n  = ~s.dp[slot];
            end
        end
        return o;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            m[k].active = 0; m[k].t = 0; m[k].d = '0; m[k].dp = '0; m[k].bl = '0;
        end
        forever begin
            @(posedge clk or posedge rst);
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    m[k].active = 0;
                    m[k].t = 0;
                end else if (!m[k].active) begin
                    if (en) begin
                        m[k].active = 1;
                        m[k].t = 0;
                    end
                end else begin
                    if (m[k].t == 0) begin
                        m[k].d = din; m[k].dp = dp_in; m[k].bl = blank_in;
                    end
                    if (!en) m[k].active = 0;
                    else m[k].t = (m[k].t + 1) % (1 + N * (S + blank_cyc[k]));
                end
            end
        end
    end

    initial begin
        out_t e;
        forever begin
            @(negedge clk);
            if (run_cmp) begin
                e = expect_out(m[0], blank_cyc[0]);
                chk("model_a", {fs_a, sel_a, code_a, dp_a}, e);
                e = expect_out(m[1], blank_cyc[1]);
                chk("model_b", {fs_b, sel_b, code_b, dp_b}, e);
                chk("onehot_a", ($countones(~sel_a) <= 1), 1);
                chk("onehot_b", ($countones(~sel_b) <= 1), 1);
            end
        end
    end

    task automatic wait_fs_a(input int lim);
        int n = 0;
        while (fs_a !== 1'b1 && n < lim) begin @(negedge clk); n++; end
        chk("wait_fs_a", fs_a, 1);
    endtask

    task automatic wait_fs_b(input int lim);
        int n = 0;
        while (fs_b !== 1'b1 && n < lim) begin @(negedge clk); n++; end
        chk("wait_fs_b", fs_b, 1);
    endtask

    // Called on the negedge of a snapshot cycle; returns on the next one (17-cycle period).
    task automatic frame_a(input logic [15:0] d, input logic [3:0] bl, input int chg, input logic [15:0] nd);
        int slot;
        logic [7:0] want;
        chk("fs_a_period", fs_a, 1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            slot = i / 4;
            if (i % 4 < 3 && !bl[slot]) want = {lit_sel[slot], d[slot*4 +: 4]};
            else want = 8'hFB;
            chk("frame_a", {sel_a, code_a}, want);
            chk("frame_a_fs", fs_a, 0);
            if (i == chg) din = nd;
        end
        @(negedge clk);
    endtask

    task automatic frame_b(input logic [15:0] d);
        int slot;
        chk("fs_b_period", fs_b, 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            slot = i / 3;
            chk("frame_b", {sel_b, code_b, dp_b}, {lit_sel[slot], d[slot*4 +: 4], (slot != 0)});
        end
        @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b1;
        run_cmp = 1'b1;
        #1;
        chk("reset_a", {fs_a, sel_a, code_a, dp_a}, {1'b0, 4'hF, 4'hB, 1'b1});
        chk("reset_b", {fs_b, sel_b, code_b, dp_b}, {1'b0, 4'hF, 4'hB, 1'b1});
        repeat (3) @(negedge clk);
        rst = 1'b0; en = 1'b1; din = 16'h4321; dp_in = 4'b0001;
        @(negedge clk);
        wait_fs_a(10);

        frame_a(16'h4321, 4'b0000, -1, 16'h0);
        frame_a(16'h4321, 4'b0000, -1, 16'h0);
        blank_in = 4'b0100;
        frame_a(16'h4321, 4'b0100, -1, 16'h0);
        blank_in = 4'b0000;
        frame_a(16'h4321, 4'b0000, 5, 16'h9999);
        frame_a(16'h9999, 4'b0000, -1, 16'h0);

        din = 16'h4321;
        @(negedge clk);
        wait_fs_b(20);
        @(negedge clk);
        wait_fs_b(20);
        frame_b(16'h4321);
        frame_b(16'h4321);

        @(negedge clk);
        wait_fs_a(20);
        repeat (5) @(negedge clk);
        en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("disable_a", {fs_a, sel_a, code_a, dp_a}, {1'b0, 4'hF, 4'hB, 1'b1});
            chk("disable_b", {fs_b, sel_b, code_b, dp_b}, {1'b0, 4'hF, 4'hB, 1'b1});
        end
        en = 1'b1;
        @(negedge clk);
        chk("reenable_fs_b", fs_b, 1);
        frame_a(16'h4321, 4'b0000, -1, 16'h0);

        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_a", {fs_a, sel_a, code_a, dp_a}, {1'b0, 4'hF, 4'hB, 1'b1});
        chk("rst_async_b", {fs_b, sel_b, code_b, dp_b}, {1'b0, 4'hF, 4'hB, 1'b1});
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_a", {fs_a, sel_a, code_a, dp_a}, {1'b0, 4'hF, 4'hB, 1'b1});
        end
        #2 rst = 1'b0;

        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) din = 16'($urandom);
            if ($urandom_range(7) == 0) dp_in = 4'($urandom);
            if ($urandom_range(7) == 0) blank_in = 4'($urandom);
            if (en && $urandom_range(39) == 0) en = 1'b0;
            else if (!en && $urandom_range(3) == 0) en = 1'b1;
            if ($urandom_range(499) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the clock's 8-digit common-anode 7-segment display. It snapshots the packed BCD/hex digit values once per frame. It then steps one digit at a time, driving the 4-bit code into the team's 7-segment decoder together with an active-low digit select and decimal point. A blanking gap between digits suppresses ghosting. The block sits between the time-keeping counters and the decoder/pin outputs.

Parameters:
NUM_DIG, 8, number of digits scanned (>=2)
SHOW_CYC, 50000, clk cycles each digit is lit (>=1; 1 ms at 50 MHz)
BLANK_CYC, 500, clk cycles all digits are off between digits (>=0; 0 = no gap)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
en  in  1  scan enable; low forces display off
din  in  4*NUM_DIG  digit codes; digit i = din[4i+3:4i]; digit 0 is the rightmost
dp_in  in  NUM_DIG  decimal point request per digit, active-high
blank_in  in  NUM_DIG  per-digit blank (leading-zero suppression), active-high
code  out  4  digit code to decoder; 4'hB = all segments off
sel_n  out  NUM_DIG  digit select, one-hot active-low
dp_n  out  1  decimal point, active-low
frame_start  out  1  one-cycle pulse at each snapshot

Behaviour:
- One clock: clk. Reset is asynchronous and active-high on rst.
- All outputs are driven directly from flops, with no combinational path from inputs. Outputs are computed from next-state so they match the FSM state in the same cycle.
- Reset values: state=IDLE, idx=0, cnt=0, snapshots=0, sel_n=all 1, code=4'hB, dp_n=1, frame_start=0. rst takes effect immediately, mid-operation included.
- FSM states: IDLE, LOAD, SHOW, BLANK.
- IDLE: display off (sel_n all 1, code=B, dp_n=1). If en=1, go to LOAD on the next edge.
- LOAD: lasts 1 cycle.
  - Capture din, dp_in and blank_in into the snapshot regs.
  - idx=0, frame_start=1 (high only in LOAD).
  - Display off. Go to SHOW.
- SHOW: lasts SHOW_CYC cycles.
  - sel_n = ~(1<<idx), code = snap digit[idx], dp_n = ~snap_dp[idx].
  - If snap_blank[idx]=1: sel_n all 1, code=B, dp_n=1. Slot timing is unchanged.
  - After the last cycle, go to BLANK if BLANK_CYC>0. Otherwise advance the digit directly.
- BLANK: lasts BLANK_CYC cycles, display off.
- Digit advance, at the end of SHOW/BLANK:
  - If idx<NUM_DIG-1: idx+1, go to SHOW.
  - If idx=NUM_DIG-1: go to LOAD (or IDLE if en=0).
- Frame period: 1 + NUM_DIG*(SHOW_CYC+BLANK_CYC) cycles. Consecutive frames have no gap.
- cnt is a down-counter loaded with SHOW_CYC-1 or BLANK_CYC-1 on state entry. Width = clog2(max(SHOW_CYC,BLANK_CYC)+1). No wrap is permitted.
- en=0 sampled in any state other than IDLE: go to IDLE on the next edge, display off that cycle. Re-enable always restarts at LOAD with digit 0, never mid-frame.
- din, dp_in and blank_in changes between LOADs are ignored until the next LOAD. There is no tearing within a frame.
- en=1 and a frame end in the same cycle: LOAD, as the normal continuation.
- Never more than one sel_n bit is low. sel_n changes only on SHOW entry/exit.

Test Plan:
Common bench parameters: NUM_DIG=4, SHOW_CYC=3, BLANK_CYC=1.
1. Assert rst asynchronously mid-SHOW (between edges) -> sel_n=4'hF, code=B, dp_n=1, frame_start=0 immediately. Outputs stay there while rst=1.
2. en=1, din=16'h4321, dp_in=0, blank_in=0 -> frame_start for 1 cycle. Then:
   - sel_n=1110/code=1 for 3 cycles, then 1111/B for 1 cycle.
   - Then 1101/2, 1011/3, 0111/4 with the same timing.
   - frame_start repeats every 17 cycles.
3. blank_in=4'b0100 -> the digit-2 slot shows sel_n=1111, code=B for 3 cycles. The other digits and the 17-cycle period are unchanged.
4. din changes to 16'h9999 during the digit-1 SHOW -> the current frame still shows 1,2,3,4. The next frame shows 9 on all digits.
5. Drop en during the digit-1 SHOW -> the next cycle is IDLE with outputs off and no frame_start. Re-raise en -> LOAD, frame_start, restart at digit 0.
6. Rebuild with BLANK_CYC=0 and dp_in=4'b0001 -> digits are back-to-back with no all-off cycle, and the period is 13 cycles. dp_n=0 only during the digit-0 SHOW.
